// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions used by both the receiver and the driver.
// Holds protocol timing in 20 MHz clock cycles (50 ns each), the pixel and
// frame buffer address widths, and the receiver decoder state encoding.
package ws2812b_pkg;

    // Pixel word width; bit 23 is the first bit on the wire.
    localparam int PIXEL_W = 24;

    // Frame buffer address width (1024 pixels).
    localparam int ADDR_W = 10;

    // Driver high times for a 0 and a 1, and the full bit period.
    localparam int T0H   = 8;
    localparam int T1H   = 16;
    localparam int T_BIT = 25;

    // Low time that marks the end of a frame (50 us).
    localparam int LATCH_CYCLES = 1000;

    // Receiver pulse classification thresholds.
    localparam int MIN_HIGH   = 4;
    localparam int BIT_THRESH = 12;
    localparam int MAX_HIGH   = 30;

    // Receiver decoder states.
    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } ws_state_e;

endpackage

// File: rtl/din_sync.sv
// Brings the asynchronous WS2812B line into the clock domain and produces
// one-cycle rise/fall strobes. The level output is delayed by one register
// so that it lines up with the strobes: the first cycle with level_o high
// is the cycle in which rise_o is asserted, and likewise for fall_o.
module din_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic level_q;
    logic rise_q;
    logic fall_q;

    // Two-stage synchronizer, an aligned level copy and registered edge strobes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            rise_q  <= sync2_q & ~level_q;
            fall_q  <= ~sync2_q & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812B receiver: measures high pulses on the synchronized line, shifts
// decoded bits MSB first into a pixel word and writes each completed pixel
// into frame buffer port A at consecutive addresses. A long low period ends
// the frame and reports how many pixels were stored. Stuck-high lines and
// frames ending mid-pixel raise a one-cycle error pulse; after a stuck-high
// error or a reset the decoder waits for a clean latch-length low period
// before it trusts the line again.
module ws2812b_receiver #(
    parameter int ADDR_W       = ws2812b_pkg::ADDR_W,
    parameter int NUM_PIXELS   = 1024,
    parameter int MIN_HIGH     = ws2812b_pkg::MIN_HIGH,
    parameter int BIT_THRESH   = ws2812b_pkg::BIT_THRESH,
    parameter int MAX_HIGH     = ws2812b_pkg::MAX_HIGH,
    parameter int LATCH_CYCLES = ws2812b_pkg::LATCH_CYCLES
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DIN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [23:0]       RAM_DATA,
    output logic              FRAME_DONE,
    output logic [ADDR_W:0]   PIXEL_COUNT,
    output logic              ERROR
);

    import ws2812b_pkg::*;

    localparam int HI_W  = $clog2(MAX_HIGH + 1);
    localparam int LO_W  = $clog2(LATCH_CYCLES + 1);
    localparam int IDX_W = ADDR_W + 1;

    localparam logic [HI_W-1:0]  MIN_HIGH_C   = HI_W'(MIN_HIGH);
    localparam logic [HI_W-1:0]  BIT_THRESH_C = HI_W'(BIT_THRESH);
    localparam logic [HI_W-1:0]  MAX_HIGH_C   = HI_W'(MAX_HIGH);
    localparam logic [HI_W-1:0]  HI_ONE_C     = HI_W'(1);
    localparam logic [LO_W-1:0]  LATCH_C      = LO_W'(LATCH_CYCLES);
    localparam logic [LO_W-1:0]  LO_ONE_C     = LO_W'(1);
    localparam logic [IDX_W-1:0] NUM_PIX_C    = IDX_W'(NUM_PIXELS);
    localparam logic [4:0]       LAST_BIT_C   = 5'(PIXEL_W - 1);

    // Synchronized line view, all three aligned to the same cycle.
    logic level;
    logic rise;
    logic fall;

    din_sync u_din_sync (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .din_i   (DIN),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Decoder state.
    ws_state_e           state_q;
    logic                fromIdle_q;
    logic [HI_W-1:0]     hiCnt_q;
    logic [LO_W-1:0]     lowCnt_q;
    logic [4:0]          bitCnt_q;
    logic [PIXEL_W-2:0]  shift_q;
    logic [IDX_W-1:0]    pixIdx_q;

    // Registered outputs.
    logic                ramWe_q;
    logic [ADDR_W-1:0]   ramAddr_q;
    logic [PIXEL_W-1:0]  ramData_q;
    logic                frameDone_q;
    logic [IDX_W-1:0]    pixelCount_q;
    logic                error_q;

    // Value of the bit just finished and the pixel word including it.
    logic                bitValue_d;
    logic [PIXEL_W-1:0]  shift_d;

    // The measured high time decides the bit; the new bit enters at the LSB.
    always_comb begin
        bitValue_d = (hiCnt_q >= BIT_THRESH_C);
        shift_d    = {shift_q, bitValue_d};
    end

    // Decoder FSM with counters, pixel assembly, frame buffer writes and status pulses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_RESYNC;
            fromIdle_q   <= 1'b0;
            hiCnt_q      <= '0;
            lowCnt_q     <= '0;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            pixIdx_q     <= '0;
            ramWe_q      <= 1'b0;
            ramAddr_q    <= '0;
            ramData_q    <= '0;
            frameDone_q  <= 1'b0;
            pixelCount_q <= '0;
            error_q      <= 1'b0;
        end else begin
            ramWe_q     <= 1'b0;
            frameDone_q <= 1'b0;
            error_q     <= 1'b0;

            case (state_q)
                ST_RESYNC: begin
                    if (level) begin
                        lowCnt_q <= '0;
                    end else if (lowCnt_q >= LATCH_C) begin
                        state_q  <= ST_IDLE;
                        lowCnt_q <= '0;
                        bitCnt_q <= '0;
                        pixIdx_q <= '0;
                    end else begin
                        lowCnt_q <= lowCnt_q + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (rise) begin
                        state_q    <= ST_HIGH;
                        hiCnt_q    <= HI_ONE_C;
                        fromIdle_q <= 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (hiCnt_q >= MAX_HIGH_C) begin
                        error_q  <= 1'b1;
                        bitCnt_q <= '0;
                        lowCnt_q <= '0;
                        state_q  <= ST_RESYNC;
                    end else if (fall) begin
                        if (hiCnt_q < MIN_HIGH_C) begin
                            state_q <= fromIdle_q ? ST_IDLE : ST_LOW;
                        end else begin
                            state_q  <= ST_LOW;
                            lowCnt_q <= LO_ONE_C;
                            shift_q  <= shift_d[PIXEL_W-2:0];
                            if (bitCnt_q == LAST_BIT_C) begin
                                bitCnt_q <= '0;
                                if (pixIdx_q < NUM_PIX_C) begin
                                    ramWe_q   <= 1'b1;
                                    ramAddr_q <= pixIdx_q[ADDR_W-1:0];
                                    ramData_q <= shift_d;
                                    pixIdx_q  <= pixIdx_q + 1'b1;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 1'b1;
                            end
                        end
                    end else begin
                        hiCnt_q <= hiCnt_q + 1'b1;
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        state_q    <= ST_HIGH;
                        hiCnt_q    <= HI_ONE_C;
                        fromIdle_q <= 1'b0;
                    end else if (lowCnt_q >= LATCH_C) begin
                        frameDone_q  <= 1'b1;
                        pixelCount_q <= pixIdx_q;
                        error_q      <= (bitCnt_q != 5'd0);
                        bitCnt_q     <= '0;
                        pixIdx_q     <= '0;
                        lowCnt_q     <= '0;
                        state_q      <= ST_IDLE;
                    end else begin
                        lowCnt_q <= lowCnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_RESYNC;
                end
            endcase
        end
    end

    assign RAM_WE      = ramWe_q;
    assign RAM_ADDR    = ramAddr_q;
    assign RAM_DATA    = ramData_q;
    assign FRAME_DONE  = frameDone_q;
    assign PIXEL_COUNT = pixelCount_q;
    assign ERROR       = error_q;

endmodule

// File: doc/ws2812b_receiver.md
# ws2812b_receiver

Decodes a WS2812B single-wire bit stream on `DIN` into 24-bit pixel words and writes them sequentially into the frame buffer's write port (port A, 10-bit address, 24-bit data). It is the receive end of the protocol `ws2812b_driver` transmits. Words are stored in transmission order, so the driver re-emits a received frame bit-identically. It runs in the 20 MHz domain; all timing parameters are in clock cycles at 50 ns.

## Interface
- `ADDR_W`, 10: frame buffer address width.
- `NUM_PIXELS`, 1024: pixels accepted per frame; later pixels are dropped.
- `MIN_HIGH`, 4: high pulses shorter than this are glitches.
- `BIT_THRESH`, 12: a high pulse of at least this many cycles decodes as 1, otherwise 0.
- `MAX_HIGH`, 30: a high pulse reaching this length is a stuck-high error.
- `LATCH_CYCLES`, 1000: low time that marks a latch/reset (50 µs).
- `CLK` in 1: 20 MHz clock; the only clock.
- `RESET` in 1: asynchronous, active-high reset.
- `DIN` in 1: asynchronous WS2812B serial input.
- `RAM_WE` out 1: one-cycle write strobe to frame buffer port A (drives `ena`/`wea`).
- `RAM_ADDR` out ADDR_W: write address.
- `RAM_DATA` out 24: write data; bit 23 is the first bit received.
- `FRAME_DONE` out 1: one-cycle pulse on latch detection after at least one decoded bit.
- `PIXEL_COUNT` out ADDR_W+1: pixels written in the last completed frame; valid from `FRAME_DONE`.
- `ERROR` out 1: one-cycle pulse on stuck-high or a partial pixel at latch.

## Operation
- `DIN` passes through a 2-FF synchronizer, then a registered copy feeds edge detection.
- States:
  - **RESYNC**: entered on reset and after an error. Ignores all edges and counts low cycles; any high clears the count. Reaching `LATCH_CYCLES` goes to **IDLE** with address 0 and no `FRAME_DONE`.
  - **IDLE**: line low, bit count 0. A rising edge goes to **HIGH**.
  - **HIGH**: a saturating high counter runs.
    - Falling edge with count < `MIN_HIGH`: return to the prior state (IDLE or LOW) and discard the pulse.
    - Other falling edge: shift in (count >= `BIT_THRESH`), then go to **LOW**.
    - Count reaches `MAX_HIGH`: pulse `ERROR`, drop the partial pixel, go to **RESYNC**.
  - **LOW**: a saturating low counter runs.
    - Rising edge: go to **HIGH**.
    - Count reaches `LATCH_CYCLES`: latch event.
- On the 24th bit, the shift register moves to `RAM_DATA`, `RAM_WE` pulses, `RAM_ADDR` holds the current pixel index, and the index increments after the write.
- Pixel index >= `NUM_PIXELS`: no write, index saturates at `NUM_PIXELS`, decoding continues.
- Latch event:
  - `PIXEL_COUNT` <= index; `FRAME_DONE` pulses.
  - If the bit count is nonzero, the partial pixel is discarded and `ERROR` pulses in the same cycle.
  - Index and bit count clear; go to **IDLE**.
- Counter widths: high counter `$clog2(MAX_HIGH+1)`, low counter `$clog2(LATCH_CYCLES+1)`, bit count 5 bits. All saturate; none wrap.

## Timing
- Reset values: `RAM_WE`=0, `RAM_ADDR`=0, `RAM_DATA`=0, `FRAME_DONE`=0, `PIXEL_COUNT`=0, `ERROR`=0, state RESYNC.
- Pin-to-edge latency: 3 cycles (2 sync + 1 edge register).
- `RAM_WE` asserts 4 cycles after the first `CLK` edge sampling the 24th falling edge low.
- `RAM_ADDR` and `RAM_DATA` are stable in the `RAM_WE` cycle.
- `FRAME_DONE` asserts 4 cycles after the low counter would reach `LATCH_CYCLES` at the pin.
- Back-to-back pixels need no gap; the minimum bit period of 20 cycles is always sustained.
- Reset mid-pixel or mid-frame: outputs clear immediately, the partial pixel is lost, and no write or `FRAME_DONE` is issued until after RESYNC.

## Structure
- Shared `ws2812b_pkg`, also used by `ws2812b_driver`:
  - timing constants (T0H=8, T1H=16, bit period 25, `LATCH_CYCLES`);
  - `PIXEL_W`=24 and `ADDR_W`;
  - the state enum.
- One sub-module, `din_sync`: 2-FF synchronizer plus rise/fall strobes, with reset value 0.
- In `top`, this block drives frame buffer port A on `clk_20MHz`, replacing the tied-off `ena`/`wea`/`addra`/`dina`.

## Test plan
- Single pixel: reset, 1000 low cycles, then one pixel 0xA53CF0 (8/16-cycle highs, 25-cycle period), then 1000 low cycles → one write: addr 0, data 0xA53CF0; `FRAME_DONE` with `PIXEL_COUNT`=1.
- Address sequencing: pixels 0x000001, 0x800000, 0xFFFFFF, latch, then 0x123456 → writes at addr 0, 1, 2, then addr 0; `PIXEL_COUNT`=3.
- Partial pixel: 10 bits then latch → no write; `ERROR` and `FRAME_DONE` in the same cycle; `PIXEL_COUNT`=0.
- Glitch and stuck-high:
  - A 2-cycle high pulse inside a bit's low phase → ignored; data unchanged.
  - A 40-cycle high → `ERROR`; no writes until 1000 low cycles pass.
- Overflow: `NUM_PIXELS`=4, send 6 pixels → writes at addr 0..3 only; `PIXEL_COUNT`=4.
- Reset mid-operation: assert `RESET` after bit 12 → outputs 0; resume mid-frame without a latch → no writes until a latch is seen.
